// File: rtl/encoder_pkg.sv
// Shared constants and priority-pick helper for the registered 8-to-3 priority encoder.
package encoder_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CODE_W = $clog2(WIDTH);

    typedef struct packed {
        logic              found;
        logic [CODE_W-1:0] idx;
    } pick_t;

    // Descending search from start, wrapping from 0 to WIDTH-1.
    // WIDTH is a power of two, so the wrap comes from CODE_W-bit arithmetic.
    function automatic pick_t prio_pick(input logic [WIDTH-1:0]  mask,
                                        input logic [CODE_W-1:0] start);
        pick_t             res;
        logic [CODE_W-1:0] pos;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            pos = start - CODE_W'(k);
            if (!res.found && mask[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/priority_encoder_83_prio_sel.sv
// Combinational selector: picks the first set bit of i_mask, searching downward from i_start.
module priority_encoder_83_prio_sel
    import encoder_pkg::*;
(
    input  logic [WIDTH-1:0]  i_mask,
    input  logic [CODE_W-1:0] i_start,
    output logic              o_found,
    output logic [CODE_W-1:0] o_idx
);

    pick_t w_pick;

    // Wrap-around descending search over the candidate mask.
    always_comb begin
        w_pick  = prio_pick(i_mask, i_start);
        o_found = w_pick.found;
        o_idx   = w_pick.idx;
    end

endmodule

// File: rtl/priority_encoder_83.sv
// Registered 8-to-3 priority encoder with sticky pending requests, valid/ready code
// port and 74148-style EI_n/EO_n/GS_n cascade pins.
// Optional macro ENCODER_ROUND_ROBIN_EN selects round-robin arbitration instead of
// fixed highest-index-wins priority.
module priority_encoder_83
    import encoder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ei_n,
    input  logic [WIDTH-1:0]  i_i_n,
    input  logic              i_code_rdy,
    output logic [CODE_W-1:0] o_code,
    output logic              o_code_vld,
    output logic              o_gs_n,
    output logic              o_eo_n
);

    logic [WIDTH-1:0]  r_pend;
    logic [CODE_W-1:0] r_code;
    logic              r_code_vld;
    logic              r_gs_n;
    logic              r_eo_n;

    logic [WIDTH-1:0]  w_capture;
    logic [WIDTH-1:0]  w_served;
    logic [WIDTH-1:0]  w_mask;
    logic              w_accept;
    logic              w_load_en;
    logic [CODE_W-1:0] w_start;
    logic              w_found;
    logic [CODE_W-1:0] w_idx;

    // Capture, clear-on-accept and candidate mask (the bit being served is never re-picked
    // at the same edge, even if it is recaptured).
    always_comb begin
        w_capture = {WIDTH{~i_ei_n}} & ~i_i_n;
        w_accept  = r_code_vld & i_code_rdy;
        w_served  = w_accept ? (WIDTH'(1) << r_code) : '0;
        w_mask    = r_pend & ~w_served;
        w_load_en = ~r_code_vld | w_accept;
    end

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [CODE_W-1:0] r_rr_ptr;

    // On acceptance the pointer moves to the served code in the same edge, so the
    // search for the back-to-back load already starts just below it.
    always_comb begin
        w_start = w_accept ? (r_code - CODE_W'(1)) : (r_rr_ptr - CODE_W'(1));
    end

    // Round-robin pointer tracks the most recently accepted code.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= CODE_W'(WIDTH - 1);
        end else if (w_accept) begin
            r_rr_ptr <= r_code;
        end
    end
`else
    // Fixed priority: always search from the highest index.
    always_comb begin
        w_start = CODE_W'(WIDTH - 1);
    end
`endif

    priority_encoder_83_prio_sel u_prio_sel (
        .i_mask  (w_mask),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // Pending register: set wins over a simultaneous clear of the same bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_mask | w_capture;
        end
    end

    // Code/valid output register; GS_n mirrors ~valid from the same flop stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code     <= '0;
            r_code_vld <= 1'b0;
            r_gs_n     <= 1'b1;
        end else if (w_load_en) begin
            if (w_found) begin
                r_code <= w_idx;
            end
            r_code_vld <= w_found;
            r_gs_n     <= ~w_found;
        end
    end

    // EO_n goes low when this stage is enabled and fully idle, letting a lower stage report.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_eo_n <= 1'b1;
        end else begin
            r_eo_n <= ~(~i_ei_n & (r_pend == '0) & ~r_code_vld & (&i_i_n));
        end
    end

    assign o_code     = r_code;
    assign o_code_vld = r_code_vld;
    assign o_gs_n     = r_gs_n;
    assign o_eo_n     = r_eo_n;

endmodule
